// File: rtl/cell_pkg.sv
// Shared ATM cell switch definitions: cell/port types and header field positions.
package cell_pkg;

  localparam int CELL_W    = 53;
  localparam int NUM_PORTS = 4;
  localparam int PORT_W    = 2;
  localparam int FILL_W    = 3;

  // VPI/VCI field location inside a cell word, common with the parser stage.
  localparam int VPI_VCI_MSB = 47;
  localparam int VPI_VCI_LSB = 32;

  typedef logic [CELL_W-1:0] cell_t;
  typedef logic [PORT_W-1:0] port_t;

endpackage

// File: rtl/cell_fifo.sv
// Single-clock first-word fall-through FIFO holding one output port's cells.
// The head entry is driven combinationally from the array so it is visible
// in the same cycle it becomes valid; it reads as zero while the FIFO is empty.
module cell_fifo #(
  parameter int WIDTH = 53,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_pop;
  logic w_push;

  // A pop needs data; a push needs space, or a slot freed by a pop this cycle.
  assign w_pop  = pop && (r_count != '0);
  assign w_push = push && ((r_count != FULL_CNT) || w_pop);

  assign empty = (r_count == '0);
  assign full  = (r_count == FULL_CNT);
  assign count = r_count;
  assign dout  = empty ? '0 : r_mem[r_rd_ptr];

  // Storage array; cells are written at the write pointer on an accepted push.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally at DEPTH; occupancy kept in its own counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cell_out_queue.sv
// Output queueing stage after the header parser: holds each cell for the one
// cycle until its output port is resolved, steers it into that port's FIFO,
// and drops (and counts) cells aimed at a full port.
module cell_out_queue
  import cell_pkg::*;
#(
  parameter int CELL_W    = cell_pkg::CELL_W,
  parameter int NUM_PORTS = cell_pkg::NUM_PORTS,
  parameter int DEPTH     = 4,
  parameter int DROP_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CELL_W-1:0]           cell_in,
  input  logic                        cell_valid,
  input  logic [PORT_W-1:0]           port_id,
  input  logic                        port_valid,
  output logic [NUM_PORTS*CELL_W-1:0] out_cell,
  output logic [NUM_PORTS-1:0]        out_valid,
  input  logic [NUM_PORTS-1:0]        out_ready,
  output logic [NUM_PORTS*FILL_W-1:0] fill,
  output logic [NUM_PORTS*DROP_W-1:0] drop_cnt,
  output logic                        drop_pulse
);

  logic [CELL_W-1:0]    r_align;
  logic                 r_drop_pulse;
  logic [NUM_PORTS-1:0] w_sel;
  logic [NUM_PORTS-1:0] w_push;
  logic [NUM_PORTS-1:0] w_pop;
  logic [NUM_PORTS-1:0] w_full;
  logic [NUM_PORTS-1:0] w_empty;
  logic [NUM_PORTS-1:0] w_drop;

  // Align register: holds the latest cell until the parser reports its port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_align <= '0;
    end else if (cell_valid) begin
      r_align <= cell_in;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      logic [DROP_W-1:0] r_drop_cnt;
      logic [FILL_W-1:0] w_count;

      assign w_sel[gi]  = port_valid && (port_id == PORT_W'(gi));
      assign w_pop[gi]  = out_ready[gi] && !w_empty[gi];
      assign w_push[gi] = w_sel[gi] && (!w_full[gi] || w_pop[gi]);
      assign w_drop[gi] = w_sel[gi] && w_full[gi] && !w_pop[gi];

      cell_fifo #(
        .WIDTH (CELL_W),
        .DEPTH (DEPTH),
        .CNT_W (FILL_W)
      ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push[gi]),
        .pop   (w_pop[gi]),
        .din   (r_align),
        .dout  (out_cell[gi*CELL_W +: CELL_W]),
        .empty (w_empty[gi]),
        .full  (w_full[gi]),
        .count (w_count)
      );

      // Per-port drop counter, saturating at all ones.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_drop_cnt <= '0;
        end else if (w_drop[gi] && (r_drop_cnt != '1)) begin
          r_drop_cnt <= r_drop_cnt + DROP_W'(1);
        end
      end

      assign out_valid[gi]                 = !w_empty[gi];
      assign fill[gi*FILL_W +: FILL_W]     = w_count;
      assign drop_cnt[gi*DROP_W +: DROP_W] = r_drop_cnt;
    end
  endgenerate

  // One-cycle indication, the cycle after a cell was discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_pulse <= 1'b0;
    end else begin
      r_drop_pulse <= |w_drop;
    end
  end

  assign drop_pulse = r_drop_pulse;

endmodule

// File: doc/cell_out_queue.md
Name: cell_out_queue

Overview:
- Downstream of the VPI/VCI header parser stage in the ATM cell switch.
- Pairs each 53-bit cell with the 2-bit output port the parser resolves one cycle later, and writes the cell into one of four per-port FIFOs.
- Presents each FIFO head on its own valid/ready output channel.
- Drops cells aimed at a full port and counts each drop per port.

Parameters:
- CELL_W, 53, cell word width.
- NUM_PORTS, 4, number of output ports (port id width 2).
- DEPTH, 4, cells per port FIFO (power of two, ≥2).
- DROP_W, 16, width of each drop counter.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- cell_in  input  CELL_W  cell word, same bus as the parser's input
- cell_valid  input  1  qualifies cell_in
- port_id  input  2  parser out_port; valid one cycle after its cell
- port_valid  input  1  parser valid_out
- out_cell  output  NUM_PORTS*CELL_W  FIFO heads; port p at bits [p*CELL_W +: CELL_W]
- out_valid  output  NUM_PORTS  FIFO p non-empty
- out_ready  input  NUM_PORTS  consumer accepts head of port p
- fill  output  NUM_PORTS*3  occupancy per port, 0..DEPTH
- drop_cnt  output  NUM_PORTS*DROP_W  saturating drop counters
- drop_pulse  output  1  one-cycle pulse when a cell is dropped

Behaviour:
- Reset state:
  - All FIFOs empty; out_valid=0, fill=0, drop_cnt=0, drop_pulse=0.
  - Align register cleared to 0. out_cell is don't-care while out_valid=0; it reads 0 after reset.
- Alignment:
  - When cell_valid=1, the align register loads cell_in.
  - When port_valid=1, the align register's current contents are enqueued into FIFO[port_id].
  - Back-to-back cells are legal: if cell_valid and port_valid are both 1 in the same cycle, the old contents are enqueued and the new cell is loaded.
- Latency: cell_in/cell_valid at cycle T → port_valid at T+1 → enqueue at the T+1 edge → out_valid[p]=1 in cycle T+2.
- Output handshake, per port, independent:
  - First-word fall-through: out_cell[p] is the head whenever out_valid[p]=1.
  - A pop occurs when out_valid[p]=1 and out_ready[p]=1; the next entry, if any, is presented the following cycle.
  - out_ready while empty has no effect.
  - Once asserted, out_valid/out_cell stay stable until popped.
- Full and drop:
  - When port_valid=1 and FIFO[port_id] is full with no pop that cycle, the cell is discarded.
  - On a discard: drop_cnt[port_id] increments, saturating at 2^DROP_W−1, and drop_pulse=1 in the next cycle. Other ports are unaffected.
- Simultaneous push and pop on the same port:
  - When full: the push is accepted, fill stays DEPTH, no drop.
  - When empty: the push is accepted, no pop occurs, fill becomes 1.
  - Otherwise: fill is unchanged.
- Pointers: read/write pointers wrap modulo DEPTH. fill is computed from a separate counter, not from pointer difference.
- Reset mid-operation: all queued cells are discarded immediately and counters are cleared. A port_valid arriving in the first cycle after reset release enqueues the cleared align register (0). Integration must therefore release rst to both stages together.

Decomposition:
- Package cell_pkg:
  - Constants CELL_W=53, NUM_PORTS=4, PORT_W=2.
  - Typedef cell_t (logic [CELL_W-1:0]) and port_t (logic [PORT_W-1:0]).
  - Header field positions: VPI/VCI = bits [47:32], shared with the parser stage.
- Sub-module cell_fifo:
  - Single-clock, first-word fall-through, DEPTH entries.
  - Ports: push, pop, din, dout, empty, full, count.
  - Instantiated NUM_PORTS times by a generate loop.
- Top level holds: the align register, push demux, drop logic and counters.

Test Plan:
1. Single cell: cell_in=53'h0_1001_xxxx…, cell_valid at T; port_id=0, port_valid at T+1 → out_valid[0]=1 at T+2 with matching out_cell; out_ready[0]=1 → empty next cycle, fill[0]=0.
2. Back-to-back to ports 1,2,3: cells A,B,C on consecutive cycles → each appears on its port at T+2, T+3, T+4; no cross-port leakage.
3. Overflow: 6 cells to port 2 with out_ready=0, DEPTH=4 → fill[2]=4, drop_cnt[2]=2, two drop_pulse cycles; popping then returns the first four cells in order.
4. Full plus simultaneous pop/push on port 1 → no drop, fill stays 4, order preserved.
5. Reset asserted with 3 cells queued mid-pop → out_valid=0, fill=0, drop_cnt=0 asynchronously; a new cell after release is delivered normally.
6. Saturation: with DROP_W forced to 4, 20 drops to port 3 → drop_cnt[3]=15 and holds.
